fwd_hazard_unit: RTL and testbench



---
 rtl/fwd_hazard_unit.sv | 145 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit for a 5-stage pipeline; shadows EX/MEM destination info.
// Optional FWD_PERF_CNT_EN adds stall_cnt / fwd_cnt performance counters.

module fwd_sel_lane #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_uses,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic                  i_take,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_reg_write,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_mem_valid,
    input  logic                  i_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    output logic                  o_hit_ex,
    output logic [1:0]            o_sel_nxt
);
    logic w_nz;
    logic w_hit_mem;

    assign w_nz      = (i_rs != '0);
    assign o_hit_ex  = i_ex_valid & i_ex_reg_write & (i_ex_rd == i_rs) & w_nz;
    assign w_hit_mem = i_mem_valid & i_mem_reg_write & (i_mem_rd == i_rs) & w_nz;

    // A load in EX has no ALU result yet; it is picked up from WB after the stall.
    always_comb begin
        o_sel_nxt = 2'b00;
        if (i_take && i_uses) begin
            if (o_hit_ex && !i_ex_mem_read) o_sel_nxt = 2'b10;
            else if (w_hit_mem)             o_sel_nxt = 2'b01;
        end
    end
endmodule

module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  ex_bubble
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           fwd_cnt
`endif
);
    localparam int NUM_OPS = 2;

    logic                  r_ex_valid, r_ex_reg_write, r_ex_mem_read;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_mem_valid, r_mem_reg_write;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic [NUM_OPS-1:0][1:0] r_sel;
    logic                  r_ex_bubble;

    logic [NUM_OPS-1:0][REG_ADDR_W-1:0] w_rs;
    logic [NUM_OPS-1:0]                 w_uses;
    logic [NUM_OPS-1:0]                 w_hit_ex;
    logic [NUM_OPS-1:0][1:0]            w_sel_nxt;
    logic                               w_take;

    assign w_rs   = {id_rs2, id_rs1};
    assign w_uses = {id_uses_rs2, id_uses_rs1};

    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
        fwd_sel_lane #(.REG_ADDR_W(REG_ADDR_W)) u_lane (
            .i_uses          (w_uses[gi]),
            .i_rs            (w_rs[gi]),
            .i_take          (w_take),
            .i_ex_valid      (r_ex_valid),
            .i_ex_reg_write  (r_ex_reg_write),
            .i_ex_mem_read   (r_ex_mem_read),
            .i_ex_rd         (r_ex_rd),
            .i_mem_valid     (r_mem_valid),
            .i_mem_reg_write (r_mem_reg_write),
            .i_mem_rd        (r_mem_rd),
            .o_hit_ex        (w_hit_ex[gi]),
            .o_sel_nxt       (w_sel_nxt[gi])
        );
    end

    // Flush squashes the decode slot, so it masks the load-use stall.
    assign stall  = id_valid & ~flush & r_ex_mem_read & |(w_uses & w_hit_ex);
    assign w_take = id_valid & ~flush & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid      <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_rd         <= '0;
            r_mem_valid     <= 1'b0;
            r_mem_reg_write <= 1'b0;
            r_mem_rd        <= '0;
            r_sel           <= '0;
            r_ex_bubble     <= 1'b1;
        end else begin
            r_ex_valid      <= w_take;
            r_ex_reg_write  <= w_take & id_reg_write;
            r_ex_mem_read   <= w_take & id_mem_read;
            r_ex_rd         <= w_take ? id_rd : '0;
            r_mem_valid     <= r_ex_valid;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_rd        <= r_ex_rd;
            r_sel           <= w_sel_nxt;
            r_ex_bubble     <= ~w_take;
        end
    end

    assign fwd_a_sel = r_sel[0];
    assign fwd_b_sel = r_sel[1];
    assign ex_bubble = r_ex_bubble;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_fwd_cnt;

    // One fwd count per edge, however many operands forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (stall)      r_stall_cnt <= r_stall_cnt + 32'd1;
            if (|w_sel_nxt) r_fwd_cnt   <= r_fwd_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: reset, EX/MEM forwarding, priority, load-use, x0, flush, counters.
`timescale 1ns/1ps

module tb_fwd_hazard_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
    logic       stall, ex_bubble;
    logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .stall(stall),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_bubble(ex_bubble)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one decode slot at the falling edge.
    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
    endtask

    task automatic idle_now();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_a", fwd_a_sel, 2'b00);
        chk("rst_b", fwd_b_sel, 2'b00);
        chk("rst_bubble", ex_bubble, 1'b1);
        chk("rst_stall", stall, 1'b0);

        // Reset while a load to r5 sits in EX and a consumer is in decode
        issue(1, 0, 0, 0, 0, 5, 1, 1, 0);
        tick();
        chk("lw_r5_in_ex", ex_bubble, 1'b0);
        issue(1, 5, 0, 1, 0, 6, 1, 0, 0);
        #1 chk("pre_rst_stall", stall, 1'b1);
        #1 rst = 1'b1;
        #1 chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_bubble", ex_bubble, 1'b1);
        #1 rst = 1'b0;
        idle_now();
        tick();
        chk("post_rst_a", fwd_a_sel, 2'b00);
        chk("post_rst_b", fwd_b_sel, 2'b00);
        chk("post_rst_bubble", ex_bubble, 1'b1);

        // EX-EX: add r3<-r1,r2 ; sub r4<-r3,r3
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
        tick();
        chk("add_a", fwd_a_sel, 2'b00);
        chk("add_b", fwd_b_sel, 2'b00);
        issue(1, 3, 3, 1, 1, 4, 1, 0, 0);
        #1 chk("exex_stall", stall, 1'b0);
        tick();
        chk("exex_a", fwd_a_sel, 2'b10);
        chk("exex_b", fwd_b_sel, 2'b10);
        chk("exex_bubble", ex_bubble, 1'b0);

        // r7 written at distance 2 -> WB select
        issue(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        issue(1, 7, 1, 1, 1, 8, 1, 0, 0);
        tick();
        chk("mem_a", fwd_a_sel, 2'b01);
        chk("mem_b", fwd_b_sel, 2'b00);

        // r7 written at distances 1 and 2 -> younger wins
        issue(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        issue(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        issue(1, 0, 7, 1, 1, 11, 1, 0, 0);
        tick();
        chk("prio_a", fwd_a_sel, 2'b00);
        chk("prio_b", fwd_b_sel, 2'b10);

        // Load-use: lw r9 ; add r10<-r9,r0
        issue(1, 0, 0, 0, 0, 9, 1, 1, 0);
        tick();
        issue(1, 9, 0, 1, 1, 10, 1, 0, 0);
        #1 chk("lu_stall", stall, 1'b1);
        tick();
        chk("lu_bubble", ex_bubble, 1'b1);
        chk("lu_bub_a", fwd_a_sel, 2'b00);
        chk("lu_bub_b", fwd_b_sel, 2'b00);
        chk("lu_stall_drop", stall, 1'b0);
        tick();
        chk("lu_a", fwd_a_sel, 2'b01);
        chk("lu_b", fwd_b_sel, 2'b00);
        chk("lu_ex_valid", ex_bubble, 1'b0);

        // x0 producer never forwarded, x0 load never stalls
        issue(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        issue(1, 0, 0, 1, 1, 12, 1, 0, 0);
        tick();
        chk("x0_a", fwd_a_sel, 2'b00);
        chk("x0_b", fwd_b_sel, 2'b00);
        issue(1, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        issue(1, 0, 0, 1, 1, 13, 1, 0, 0);
        #1 chk("x0_load_stall", stall, 1'b0);

        // Flush beats load-use stall
        issue(1, 0, 0, 0, 0, 9, 1, 1, 0);
        tick();
        issue(1, 9, 9, 1, 1, 14, 1, 0, 1);
        #1 chk("flush_stall", stall, 1'b0);
        tick();
        chk("flush_bubble", ex_bubble, 1'b1);
        chk("flush_a", fwd_a_sel, 2'b00);
        chk("flush_b", fwd_b_sel, 2'b00);

`ifdef FWD_PERF_CNT_EN
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1 rst = 1'b0;
        chk("cnt_rst_stall", stall_cnt, 32'd0);
        chk("cnt_rst_fwd", fwd_cnt, 32'd0);
        for (int k = 0; k < 2; k++) begin
            issue(1, 0, 0, 0, 0, 9, 1, 1, 0);
            tick();
            issue(1, 9, 0, 1, 1, 10, 1, 0, 0);
            tick();
            tick();
            issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
        tick();
        issue(1, 3, 3, 1, 1, 4, 1, 0, 0);
        tick();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("stall_cnt", stall_cnt, 32'd2);
        chk("fwd_cnt", fwd_cnt, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
